// File: rtl/road_sensor_encoder.sv
// Per-road vehicle occupancy tracker producing the 3-bit thermometer sensor code.
// Optional macro FAST_EMPTY_EN: an empty road drops to EMPTY at once instead of waiting out the hold filter.
module road_sensor_encoder #(
  parameter int CNT_W   = 6,
  parameter int MAX_CNT = 63,
  parameter int LESS_TH = 1,
  parameter int MORE_TH = 8,
  parameter int FULL_TH = 16,
  parameter int HYST    = 2,
  parameter int HOLD    = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             car_in,
  input  logic             car_out,
  input  logic [1:0]       light,
  output logic [2:0]       S,
  output logic [CNT_W-1:0] count,
  output logic             red_run,
  output logic             ovf,
  output logic             udf
);

  localparam int HOLD_W = (HOLD > 2) ? $clog2(HOLD) : 1;

  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] LESS_C    = CNT_W'(LESS_TH);
  localparam logic [CNT_W-1:0] MORE_C    = CNT_W'(MORE_TH);
  localparam logic [CNT_W-1:0] FULL_C    = CNT_W'(FULL_TH);
  localparam logic [CNT_W-1:0] MORE_DN_C = CNT_W'(MORE_TH - HYST);
  localparam logic [CNT_W-1:0] FULL_DN_C = CNT_W'(FULL_TH - HYST);
  localparam logic [HOLD_W:0]  HOLD_C    = (HOLD_W + 1)'(HOLD);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LESS  = 2'd1,
    MORE  = 2'd2,
    FULL  = 2'd3
  } level_t;

  level_t            level;
  level_t            candidate;
  level_t            up_target;
  level_t            target;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W:0]   hold_next;

  function automatic logic [2:0] therm(input level_t l);
    case (l)
      FULL:    therm = 3'b111;
      MORE:    therm = 3'b011;
      LESS:    therm = 3'b001;
      default: therm = 3'b000;
    endcase
  endfunction

  // Rising moves follow the raw thresholds; falling moves cascade one band at a
  // time so each step must clear its own hysteresis margin.
  always_comb begin
    up_target = EMPTY;
    if (count >= FULL_C)
      up_target = FULL;
    else if (count >= MORE_C)
      up_target = MORE;
    else if (count >= LESS_C)
      up_target = LESS;

    target = level;
    if (up_target > level) begin
      target = up_target;
    end else begin
      if (target == FULL && count < FULL_DN_C)
        target = MORE;
      if (target == MORE && count < MORE_DN_C)
        target = LESS;
      if (target == LESS && count == '0)
        target = EMPTY;
    end

    hold_next = (HOLD_W + 1)'(1);
    if (target == candidate)
      hold_next = {1'b0, hold_cnt} + (HOLD_W + 1)'(1);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count     <= '0;
      S         <= 3'b000;
      level     <= EMPTY;
      candidate <= EMPTY;
      hold_cnt  <= '0;
      red_run   <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      // Light value 3 is treated the same as RED.
      red_run <= car_out && (light != 2'd1) && (light != 2'd2);

      case ({car_in, car_out})
        2'b10: begin
          if (count == MAX_C)
            ovf <= 1'b1;
          else
            count <= count + CNT_W'(1);
        end
        2'b01: begin
          if (count == '0)
            udf <= 1'b1;
          else
            count <= count - CNT_W'(1);
        end
        default: ;
      endcase

      if (target == level) begin
        hold_cnt <= '0;
`ifdef FAST_EMPTY_EN
      end else if (target == EMPTY) begin
        level     <= EMPTY;
        candidate <= EMPTY;
        S         <= 3'b000;
        hold_cnt  <= '0;
`endif
      end else if (hold_next >= HOLD_C) begin
        level     <= target;
        candidate <= target;
        S         <= therm(target);
        hold_cnt  <= '0;
      end else begin
        candidate <= target;
        hold_cnt  <= hold_next[HOLD_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_road_sensor_encoder.sv
// Directed bench for road_sensor_encoder: counting, hysteresis/hold filter, flags, async clear.
module tb_road_sensor_encoder;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BOGUS  = 2'd3;

  logic       clock;
  logic       clear;
  logic       car_in;
  logic       car_out;
  logic [1:0] light;
  logic [2:0] S;
  logic [5:0] count;
  logic       red_run;
  logic       ovf;
  logic       udf;

  int n_checks = 0;
  int n_fail   = 0;

  road_sensor_encoder dut (
    .clock   (clock),
    .clear   (clear),
    .car_in  (car_in),
    .car_out (car_out),
    .light   (light),
    .S       (S),
    .count   (count),
    .red_run (red_run),
    .ovf     (ovf),
    .udf     (udf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with the given pulses; outputs are sampled 1 time unit later.
  task automatic cyc(input logic ci, input logic co, input logic [1:0] lt);
    car_in  = ci;
    car_out = co;
    light   = lt;
    @(posedge clock);
    #1;
    car_in  = 1'b0;
    car_out = 1'b0;
    $display("txn in=%0b out=%0b light=%0d -> count=%0d S=%b red_run=%0b ovf=%0b udf=%0b",
             ci, co, lt, count, S, red_run, ovf, udf);
  endtask

  initial begin
    clear   = 1'b1;
    car_in  = 1'b0;
    car_out = 1'b0;
    light   = RED;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", count, 0);
    check("rst_S", S, 0);
    check("rst_flags", {red_run, ovf, udf}, 0);
    clear = 1'b0;

    // First vehicle: count next edge, S after three more edges.
    cyc(1, 0, RED);
    check("first_count", count, 1);
    check("first_S0", S, 0);
    check("first_red_run", red_run, 0);
    cyc(0, 0, RED);
    check("first_S1", S, 0);
    cyc(0, 0, RED);
    check("first_S2", S, 0);
    cyc(0, 0, RED);
    check("first_S3", S, 3'b001);

    // Climb to MORE.
    repeat (7) cyc(1, 0, GREEN);
    check("climb_count", count, 8);
    check("climb_S", S, 3'b001);
    cyc(0, 0, GREEN);
    cyc(0, 0, GREEN);
    check("more_hold2", S, 3'b001);
    cyc(0, 0, GREEN);
    check("more_S", S, 3'b011);

    // Hysteresis below MORE_TH: 6 keeps MORE, 5 drops after the hold.
    cyc(0, 1, GREEN);
    cyc(0, 1, GREEN);
    check("hyst_count6", count, 6);
    check("hyst_S6", S, 3'b011);
    cyc(0, 1, GREEN);
    check("hyst_count5", count, 5);
    check("hyst_S5", S, 3'b011);
    cyc(0, 0, GREEN);
    cyc(0, 0, GREEN);
    check("drop_hold2", S, 3'b011);
    cyc(0, 0, GREEN);
    check("drop_S", S, 3'b001);

    // Red-light runs, including light value 3.
    cyc(0, 1, GREEN);
    cyc(0, 1, GREEN);
    check("pre_red_count", count, 3);
    cyc(0, 1, RED);
    check("red_count", count, 2);
    check("red_run_hi", red_run, 1);
    cyc(0, 0, GREEN);
    check("red_run_lo", red_run, 0);
    cyc(0, 1, BOGUS);
    check("bogus_count", count, 1);
    check("bogus_red_run", red_run, 1);
    cyc(0, 1, GREEN);
    check("drain_count", count, 0);
    check("drain_red_run", red_run, 0);

    // Drain to EMPTY.
    cyc(0, 0, GREEN);
`ifdef FAST_EMPTY_EN
    check("empty_e1", S, 0);
`else
    check("empty_e1", S, 3'b001);
`endif
    cyc(0, 0, GREEN);
`ifdef FAST_EMPTY_EN
    check("empty_e2", S, 0);
`else
    check("empty_e2", S, 3'b001);
`endif
    cyc(0, 0, GREEN);
    check("empty_e3", S, 0);

    // Underflow is sticky.
    cyc(0, 1, GREEN);
    check("udf_count", count, 0);
    check("udf_set", udf, 1);
    cyc(0, 0, GREEN);
    check("udf_sticky", udf, 1);

    // Saturate at MAX_CNT, overflow, collisions.
    repeat (63) cyc(1, 0, GREEN);
    check("sat_count", count, 63);
    check("sat_ovf0", ovf, 0);
    check("sat_S", S, 3'b111);
    cyc(1, 0, GREEN);
    check("ovf_count", count, 63);
    check("ovf_set", ovf, 1);
    cyc(1, 1, GREEN);
    check("coll_count", count, 63);
    check("coll_flags", {ovf, udf}, 2'b11);
    cyc(1, 1, RED);
    check("coll_red_count", count, 63);
    check("coll_red_run", red_run, 1);

    // Hysteresis below FULL_TH: 14 keeps FULL, 13 drops to MORE.
    repeat (49) cyc(0, 1, GREEN);
    check("full_count14", count, 14);
    repeat (3) cyc(0, 0, GREEN);
    check("full_S14", S, 3'b111);
    cyc(0, 1, GREEN);
    check("full_count13", count, 13);
    cyc(0, 0, GREEN);
    cyc(0, 0, GREEN);
    check("full_hold2", S, 3'b111);
    cyc(0, 0, GREEN);
    check("full_drop_S", S, 3'b011);

    // Clear is asynchronous and wipes sticky flags.
    clear = 1'b1;
    #1;
    check("clr1_count", count, 0);
    check("clr1_S", S, 0);
    check("clr1_flags", {red_run, ovf, udf}, 0);
    @(posedge clock);
    #1;
    clear = 1'b0;

    cyc(1, 1, GREEN);
    check("coll0_count", count, 0);
    check("coll0_flags", {ovf, udf}, 0);
    cyc(0, 1, GREEN);
    check("udf2_set", udf, 1);

    // Build a pending hold (S=LESS, MORE candidate two edges in), then clear mid-cycle.
    repeat (8) cyc(1, 0, GREEN);
    check("mid_count", count, 8);
    check("mid_S_less", S, 3'b001);
    cyc(0, 0, GREEN);
    cyc(0, 0, GREEN);
    check("mid_S_hold", S, 3'b001);
    #2;
    clear = 1'b1;
    #1;
    check("clr2_S", S, 0);
    check("clr2_count", count, 0);
    check("clr2_flags", {red_run, ovf, udf}, 0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    cyc(0, 0, GREEN);
    check("post_clr_count", count, 0);
    check("post_clr_S", S, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/road_sensor_encoder.md
Name: road_sensor_encoder

Overview:
Per-road occupancy tracker that produces the 3-bit thermometer sensor code consumed by the intersection light controller (one instance per road, S1..S4).
- Counts vehicles entering (upstream loop) and leaving (stop-line loop), and receives that road's light value back from the controller.
- Encodes queue occupancy as EMPTY/LESS/MORE/FULL, with hysteresis and a hold filter so the controller never sees chattering levels.
- Flags red-light runs and counter over/underflow.

Parameters:
CNT_W, 6, vehicle counter width
MAX_CNT, 63, saturation value of count (must be < 2**CNT_W)
LESS_TH, 1, count >= LESS_TH targets LESS
MORE_TH, 8, count >= MORE_TH targets MORE
FULL_TH, 16, count >= FULL_TH targets FULL
HYST, 2, downward hysteresis below MORE_TH/FULL_TH
HOLD, 3, consecutive edges a new target must persist before S changes (>=1)

Ports:
clock  input  1  single system clock, posedge
clear  input  1  asynchronous active-high reset
car_in  input  1  one-cycle pulse per vehicle entering the road segment
car_out  input  1  one-cycle pulse per vehicle crossing the stop line
light  input  2  this road's light: 0=RED, 1=YELLOW, 2=GREEN, 3 treated as RED
S  output  3  sensor code: 000 EMPTY, 001 LESS, 011 MORE, 111 FULL
count  output  CNT_W  current vehicle count
red_run  output  1  one-cycle pulse: car_out sampled while light is RED
ovf  output  1  sticky: car_in sampled with count == MAX_CNT
udf  output  1  sticky: car_out sampled with count == 0

Behaviour:
- Reset: clear asynchronous, active-high. While clear is high, count=0, S=000, level=EMPTY, candidate=EMPTY, hold_cnt=0, red_run=0, ovf=0, udf=0. Clear asserted mid-operation aborts any pending hold immediately.
- All state is registered on the posedge of clock. All outputs come directly from registers.
- Count update, applied on the edge that samples the pulses; 1-cycle latency:
  - car_in only: count+1, saturating at MAX_CNT. At MAX_CNT, count holds and ovf is set.
  - car_out only: count-1, floored at 0. At 0, count holds and udf is set.
  - car_in and car_out together: count is unchanged; no ovf or udf.
- red_run: registered for the single edge after car_out is sampled with light==RED or light==3. The decrement still happens. red_run is independent of the car_in/car_out collision.
- Target level: computed combinationally from the registered count and the current level.
  - Upward: FULL if count>=FULL_TH, else MORE if count>=MORE_TH, else LESS if count>=LESS_TH.
  - Downward, leaving FULL: requires count < FULL_TH-HYST.
  - Downward, leaving MORE: requires count < MORE_TH-HYST.
  - Downward, leaving LESS: requires count == 0.
  - Otherwise the target is the current level. Jumps may skip levels in either direction.
- Hold filter, evaluated at each edge:
  - target==level: hold_cnt<=0.
  - target!=candidate: candidate<=target, hold_cnt<=1.
  - target==candidate and hold_cnt==HOLD-1: level<=target, hold_cnt<=0.
  - else: hold_cnt<=hold_cnt+1.
  - Net effect: S changes on the HOLD-th consecutive edge with the same differing target. With HOLD=1, S updates on the first such edge.
- S is the registered thermometer encoding of level. Codes other than 000/001/011/111 never appear.
- ovf and udf clear only on clear.

Optional Feature:
FAST_EMPTY_EN
- Defined: when target is EMPTY (count==0 while level!=EMPTY), level<=EMPTY and hold_cnt<=0 on the first such edge, bypassing HOLD. The controller stops granting green to an empty road at once.
- Undefined: EMPTY obeys the normal HOLD filter like every other level.

Test Plan:
- clear high for 2 cycles, then low; car_in pulse at edge 0 (light=RED) -> count=1 after edge 0; S=000 after edges 1 and 2, S=001 after edge 3; red_run=0.
- car_in pulsed every edge 1..8 -> count=8 after edge 8; S=001 after edge 4; S=011 after edge 11.
- From count=8 with S=011: two car_out with light=GREEN -> count=6, S stays 011. One more -> count=5 (<6), S=001 after 3 further edges. Drain to 0 -> S=000 3 edges after count hits 0, or 1 edge with FAST_EMPTY_EN.
- car_out with light=RED at count=3 -> count=2, red_run high exactly one cycle. car_out at count=0 -> count=0, udf=1 and stays 1.
- Preload count=63; car_in -> count=63, ovf=1. car_in and car_out on the same edge -> count unchanged, no flag change.
- Assert clear mid-hold (count=8, hold_cnt=2, S=001) -> S=000, count=0, flags 0 immediately, without waiting for a clock edge.
